// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Snoops the core's data-store bus, captures byte stores to TX_ADDR into a
// small circular FIFO and serialises them on txd as 8N1 frames.
// Stores that arrive while the FIFO is full are counted as drops.

module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h8000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH_LOG2   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Transmitter state
    tx_state_t             state_reg;
    logic [BAUD_W-1:0]     baud_reg;
    logic [2:0]            bit_idx_reg;
    logic [7:0]            shift_reg;
    logic                  txd_reg;

    // FIFO storage and bookkeeping
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;

    // Drop accounting
    logic                  overflow_reg;
    logic [7:0]            drop_cnt_reg;

    // Decoded handshakes
    logic                  push_req;
    logic                  fifo_empty;
    logic                  full_now;
    logic                  push_ok;
    logic                  push_drop;
    logic                  baud_done;
    logic                  pop;

    // Only the low byte of a store is transmitted; the rest is ignored.
    logic                  unused_writedata_hi;
    assign unused_writedata_hi = ^writedata[31:8];

    assign push_req   = memwrite && (dataadr == TX_ADDR);
    assign fifo_empty = (count_reg == '0);
    assign full_now   = (count_reg == COUNT_FULL);
    // The full test uses occupancy before the edge, so a pop on the same
    // edge does not make room for a store that arrives while full.
    assign push_ok    = push_req && !full_now;
    assign push_drop  = push_req && full_now;
    assign baud_done  = (baud_reg == BAUD_LAST);
    // The head is taken either from idle or at the very end of a stop bit,
    // which gives back-to-back frames with no idle gap.
    assign pop        = !fifo_empty &&
                        ((state_reg == IDLE) || ((state_reg == STOP) && baud_done));

    // FIFO data array: write-only here, read by the transmitter into its shift register.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= writedata[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else if (push_drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    // 8N1 frame sequencer; txd is a register updated on each bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            txd_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    txd_reg <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        baud_reg  <= '0;
                        txd_reg   <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= 3'd0;
                        txd_reg     <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_reg  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            txd_reg   <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            // Next bit is the one about to shift into position 0.
                            txd_reg     <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            txd_reg   <= 1'b0;
                            state_reg <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    baud_reg  <= '0;
                    txd_reg   <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign txd       = txd_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;
    assign fifo_full = full_now;
    assign overflow  = overflow_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: randomized and directed store traffic, a
// transaction-level model of FIFO occupancy and frame timing, and a serial
// receiver monitor that decodes txd and checks it against a scoreboard.

module tb_mmio_uart_tx;

    localparam logic [31:0] TX_ADDR = 32'h8000_0000;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    mmio_uart_tx #(
        .TX_ADDR      (TX_ADDR),
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .txd       (txd),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: occupancy, frame-start times, drop accounting.
    int  m_occ      = 0;
    int  m_last_pop = 0;
    int  m_drops    = 0;
    bit  m_active   = 1'b0;
    bit  m_ovf      = 1'b0;
    logic [7:0] exp_data_q[$];
    int         exp_start_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        return (m_occ != 0) || (m_active && (cyc < m_last_pop + FRAME));
    endfunction

    task automatic model_reset();
        m_occ    = 0;
        m_active = 1'b0;
        m_drops  = 0;
        m_ovf    = 1'b0;
        exp_data_q.delete();
        exp_start_q.delete();
    endtask

    // One clock edge of the model: a byte leaves at most once per frame time,
    // as soon as something is queued; a store is kept only if fewer than
    // DEPTH bytes were waiting before the edge.
    task automatic model_edge(input bit mw, input logic [31:0] adr, input logic [7:0] d);
        bit do_pop;
        do_pop = (m_occ > 0) && (!m_active || (cyc >= m_last_pop + FRAME));
        if (mw && (adr == TX_ADDR)) begin
            if (m_occ < DEPTH) begin
                exp_data_q.push_back(d);
                m_occ++;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        if (do_pop) begin
            m_occ--;
            m_last_pop = cyc;
            m_active   = 1'b1;
            exp_start_q.push_back(cyc);
        end
    endtask

    // Drive one cycle of bus activity (called in the low phase), then check status.
    task automatic cycle(input bit mw, input logic [31:0] adr, input logic [7:0] d);
        memwrite  = mw;
        dataadr   = adr;
        writedata = {24'($urandom), d};
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else       model_edge(mw, adr, d);
        @(negedge clk);
        check("busy", busy, model_busy());
        check("fifo_full", fifo_full, (m_occ == DEPTH));
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drops);
        if (!model_busy()) check("txd_idle", txd, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 8'h00);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (model_busy() && n < 2000) begin
            cycle(1'b0, 32'h0, 8'h00);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        idle(2);
        check("queue_empty", exp_data_q.size(), 0);
    endtask

    // Serial receiver: samples txd every cycle in the low phase and requires
    // each bit to be constant for exactly CPB samples.
    int         mon_s;
    bit         mon_active = 1'b0;
    bit         mon_err;
    logic [9:0] mon_bits;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && (txd == 1'b0)) begin
                    mon_active = 1'b1;
                    mon_s      = 0;
                    mon_err    = 1'b0;
                    if (exp_start_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL start_cycle: unexpected start bit at cycle %0d, required none", cyc);
                    end else begin
                        check("start_cycle", cyc, exp_start_q.pop_front());
                    end
                end
                if (mon_active) begin
                    if ((mon_s % CPB) == 0) mon_bits[mon_s / CPB] = txd;
                    else if (txd != mon_bits[mon_s / CPB]) mon_err = 1'b1;
                    mon_s++;
                    if (mon_s == FRAME) begin
                        mon_active = 1'b0;
                        check("bit_stable", mon_err, 0);
                        check("stop_bit", mon_bits[9], 1);
                        if (exp_data_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL tx_byte: got unexpected frame 0x%02h, required none", mon_bits[8:1]);
                        end else begin
                            check("tx_byte", mon_bits[8:1], exp_data_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        reset = 1'b0;

        // Single byte
        cycle(1'b1, TX_ADDR, 8'h55);
        drain();

        // Address filter
        cycle(1'b1, TX_ADDR + 32'd4, 8'hAA);
        cycle(1'b0, TX_ADDR, 8'hAA);
        idle(20);
        check("filter_txd", txd, 1);
        check("filter_busy", busy, 0);

        // Overflow: 10 consecutive stores
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, TX_ADDR, 8'(i));
            if (i == 8) check("t3_full_after_9", fifo_full, 1);
        end
        check("t3_ovf", overflow, 1);
        check("t3_drop", drop_cnt, 1);
        drain();

        // Back-to-back frames
        cycle(1'b1, TX_ADDR, 8'h01);
        cycle(1'b1, TX_ADDR, 8'h80);
        drain();

        // Full FIFO with a store on the STOP->START pop edge
        for (int i = 0; i < 9; i++) cycle(1'b1, TX_ADDR, 8'(8'hC0 + i));
        check("t5_full", fifo_full, 1);
        while (cyc + 1 < m_last_pop + FRAME) cycle(1'b0, 32'h0, 8'h00);
        cycle(1'b1, TX_ADDR, 8'hEE);
        check("t5_full_after", fifo_full, 0);
        check("t5_drop", drop_cnt, 2);
        drain();

        // Reset during DATA bit 3 of a 0x0F frame with 3 bytes queued
        cycle(1'b1, TX_ADDR, 8'h0F);
        cycle(1'b1, TX_ADDR, 8'h11);
        cycle(1'b1, TX_ADDR, 8'h22);
        cycle(1'b1, TX_ADDR, 8'h33);
        while (cyc < m_last_pop + 4 * CPB + 2) cycle(1'b0, 32'h0, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("t6_txd", txd, 1);
        check("t6_busy", busy, 0);
        check("t6_full", fifo_full, 0);
        check("t6_drop", drop_cnt, 0);
        model_reset();
        idle(2);
        reset = 1'b0;
        idle(100);
        check("t6_quiet_txd", txd, 1);
        cycle(1'b1, TX_ADDR, 8'hA5);
        drain();

        // Sustained stores: drop counter saturates
        for (int i = 0; i < 320; i++) cycle(1'b1, TX_ADDR, 8'($urandom));
        check("sat_drop", drop_cnt, 255);
        check("sat_ovf", overflow, 1);
        drain();

        // Random mixed traffic with varying density
        for (int i = 0; i < 3000; i++) begin
            int r;
            int dens;
            r    = int'($urandom_range(99));
            dens = (i < 1000) ? 3 : ((i < 2000) ? 30 : 10);
            if (r < dens)           cycle(1'b1, TX_ADDR, 8'($urandom));
            else if (r < dens + 5)  cycle(1'b1, TX_ADDR + 32'(4 * $urandom_range(1, 4)), 8'($urandom));
            else if (r < dens + 10) cycle(1'b0, TX_ADDR, 8'($urandom));
            else                    cycle(1'b0, 32'($urandom), 8'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the processor/memory top level. It snoops the data-store bus (`memwrite`, `dataadr`, `writedata`) alongside data memory. It captures byte stores to one fixed address into a small FIFO and serialises them as 8N1 frames on `txd`. It gives the simulated core a console output path without changing the core or memories.

## Interface

Parameters:
- `TX_ADDR`, 32'h8000_0000, store address that the block decodes as the transmit register.
- `CLKS_PER_BIT`, 16, clock cycles per UART bit. Legal values are 2 and above.
- `DEPTH_LOG2`, 3, log2 of the FIFO depth. The default depth is 8 entries.

Ports:
- `clk`  input  1  system clock. Everything is sampled on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `memwrite`  input  1  store strobe from the core.
- `dataadr`  input  32  store address.
- `writedata`  input  32  store data. Only bits [7:0] are used.
- `txd`  output  1  serial output. Idles high.
- `busy`  output  1  high while a frame is in flight or the FIFO is non-empty.
- `fifo_full`  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- `overflow`  output  1  sticky flag. Set on the first dropped byte.
- `drop_cnt`  output  8  saturating count of dropped bytes.

## Operation

Push:
- A push is requested in a cycle where `memwrite && dataadr == TX_ADDR`.
- All other stores are ignored.
- The full test uses the FIFO occupancy before the edge.
- If the FIFO is not full, `writedata[7:0]` is written at the tail.
- If the FIFO is full, the byte is dropped. `overflow` is set to 1 and `drop_cnt` increments, saturating at 255. This holds even if a pop happens on the same edge.

FIFO:
- Circular buffer with read and write pointers of DEPTH_LOG2 bits, plus an occupancy count of DEPTH_LOG2+1 bits.
- Pointers wrap modulo the depth.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.

TX state machine:
- States are IDLE, START, DATA, STOP.
- A baud counter counts from 0 to CLKS_PER_BIT-1. A bit index runs 0..7.
- **IDLE:** `txd`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
- **START:** `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:** `txd`=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit, LSB first. After bit 7, go to STOP.
- **STOP:** `txd`=1 for CLKS_PER_BIT cycles. At the end of this bit:
  - If the FIFO is non-empty, pop and go directly to START. There is no idle gap between back-to-back frames.
  - Otherwise go to IDLE.
- `txd` is driven from a register and never glitches combinationally.

Status outputs:
- `busy` = (state != IDLE) || (count != 0).
- `fifo_full` = (count == 2^DEPTH_LOG2).
- `overflow` and `drop_cnt` clear only on reset.

## Timing

Reset:
- While `reset` is high, all registers clear asynchronously.
- Output values under reset: `txd`=1, `busy`=0, `fifo_full`=0, `overflow`=0, `drop_cnt`=0. The FIFO is empty and the state is IDLE.
- Asserting reset mid-frame aborts the frame. `txd` goes high immediately and no partial byte is retained.

Latency:
- A qualifying store sampled at edge N is in the FIFO after edge N.
- With an idle transmitter, the pop happens at edge N+1 and `txd` falls after edge N+1.
- A frame is exactly 10×CLKS_PER_BIT cycles: the start bit, 8 data bits, and the stop bit, each CLKS_PER_BIT cycles long.

Throughput:
- At most one push per cycle.
- Sustained drain rate is one byte per 10×CLKS_PER_BIT cycles.

## Test plan

1. **Single byte.** CLKS_PER_BIT=4, one store of 0x55 to TX_ADDR → `txd` falls one cycle after the store edge. Required bit pattern is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total. `busy` is high for the whole frame and then drops.
2. **Address filter.** Store of 0xAA to TX_ADDR+4, plus a cycle with `dataadr`=TX_ADDR and `memwrite`=0 → `txd` stays 1, `busy` stays 0.
3. **Overflow.** CLKS_PER_BIT=4, 10 consecutive stores to TX_ADDR with data 0x00..0x09. The first is popped immediately, leaving 8 entries, so the ninth store lands in the FIFO and the tenth store is dropped. Required results:
   - `fifo_full`=1 after the 9th store.
   - `overflow`=1 and `drop_cnt`=1 after the 10th store.
   - Transmitted bytes are 0x00..0x08, in order.
4. **Back-to-back frames.** Stores of 0x01 then 0x80 → the second start bit begins on the cycle immediately after the first stop bit ends, with no extra high cycle. The total is 80 cycles.
5. **Full plus simultaneous pop.** Hold the FIFO full. Issue a store on the same edge as the STOP→START pop → the store is dropped and `drop_cnt` increments. Afterwards the count is 7 and `fifo_full`=0.
6. **Reset mid-frame.** Assert `reset` during DATA bit 3 of a 0x0F frame, with 3 bytes queued → `txd`=1 at once, `busy`=0, and the FIFO is empty. After release, nothing is transmitted until a new store arrives.
